shot_scheduler: RTL

- Sequences player shots for the 8-column playfield.
- Accepts fire requests, allocates bullets into a small slot pool, and advances each bullet one row per game tick.
- Detects landing against the board's column heights, then arbitrates landed bullets onto a single valid/ready write port into the board manager.
- Sits between the player manager (position, fire button) and the board row-update logic; also feeds bullet sprites to the renderer.

---
 rtl/game_pkg.sv | 27 ++
 rtl/shot_slot.sv | 56 +++++
 rtl/shot_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared playfield constants, bullet slot states and shot_vis field layout
// used by the shot scheduler and its per-bullet slot.
package game_pkg;

    localparam int COLOR_W   = 5;
    localparam int DARK      = 31;
    localparam int NUM_COLS  = 8;
    localparam int EMPTY_TOP = 8;

    typedef enum logic [1:0] {
        IDLE,
        FLY,
        LAND
    } slot_state_t;

    // shot_vis slot entry: {valid, row[2:0], col[2:0], color[4:0]}
    localparam int VIS_W         = 12;
    localparam int VIS_COLOR_LSB = 0;
    localparam int VIS_COL_LSB   = 5;
    localparam int VIS_ROW_LSB   = 8;
    localparam int VIS_VALID     = 11;

    function automatic logic [3:0] top_of(input logic [31:0] tops, input logic [2:0] col);
        return tops[{col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/shot_slot.sv
// One bullet: IDLE -> FLY -> LAND -> IDLE, with its row/col/colour registers
// and the landing check against the target column's top.
module shot_slot
    import game_pkg::*;
#(
    parameter int NUM_ROWS   = 8,
    parameter int COLOR_BITS = COLOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_alloc,
    input  logic                  i_step,
    input  logic                  i_free,
    input  logic [2:0]            i_col,
    input  logic [COLOR_BITS-1:0] i_color,
    input  logic [31:0]           i_col_top,
    output slot_state_t           o_state,
    output logic [2:0]            o_row,
    output logic [2:0]            o_col,
    output logic [COLOR_BITS-1:0] o_color
);

    logic [3:0] w_top;
    logic       w_hit;

    // A bullet stops on the bottom row or directly above the column's top block.
    assign w_top = top_of(i_col_top, o_col);
    assign w_hit = (o_row == 3'(NUM_ROWS - 1)) || (w_top == ({1'b0, o_row} + 4'd1));

    // NOTE: sequential state uses non-blocking assignments so every slot and the
    // arbiter in the parent observe the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_state <= IDLE;
            o_row   <= '0;
            o_col   <= '0;
            o_color <= '0;
        end else begin
            case (o_state)
                IDLE: if (i_alloc) begin
                    o_state <= FLY;
                    o_row   <= '0;
                    o_col   <= i_col;
                    o_color <= i_color;
                end
                FLY: if (i_step) begin
                    if (w_hit) o_state <= LAND;
                    else       o_row   <= o_row + 3'd1;
                end
                LAND: if (i_free) o_state <= IDLE;
                default: o_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/shot_scheduler.sv
// Player shot scheduler: fire acceptance, slot allocation, cooldown and landing
// arbitration onto a valid/ready port. Define SHOT_AUTOFIRE_EN for level-sensitive fire.
module shot_scheduler #(
    parameter int MAX_SHOTS = 4,
    parameter int NUM_ROWS  = 8,
    parameter int COOLDOWN  = 3,
    parameter int COLOR_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   tick,
    input  logic                   fire,
    input  logic [2:0]             player_pos,
    input  logic [COLOR_W-1:0]     color_in,
    output logic                   color_req,
    input  logic [31:0]            col_top,
    output logic                   land_valid,
    input  logic                   land_ready,
    output logic [2:0]             land_col,
    output logic [2:0]             land_row,
    output logic [COLOR_W-1:0]     land_color,
    output logic [MAX_SHOTS*12-1:0] shot_vis,
    output logic                   col_full,
    output logic                   busy
);
    import game_pkg::*;

    localparam int IDX_W = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    slot_state_t          w_state [MAX_SHOTS];
    logic [2:0]           w_row   [MAX_SHOTS];
    logic [2:0]           w_col   [MAX_SHOTS];
    logic [COLOR_W-1:0]   w_color [MAX_SHOTS];
    logic [MAX_SHOTS-1:0] w_alloc;
    logic [MAX_SHOTS-1:0] w_free;

    logic [CD_W-1:0]  r_cooldown;
    logic [IDX_W-1:0] r_land_idx;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_has_free;
    logic             w_pick_ok;
    logic             w_fire_evt;
    logic             w_top_zero;
    logic             w_accept;
    logic             w_step;
    logic             w_load;

`ifdef SHOT_AUTOFIRE_EN
    assign w_fire_evt = fire;
`else
    logic r_fire_d;
    always_ff @(posedge clk) begin
        if (rst) r_fire_d <= 1'b0;
        else     r_fire_d <= fire;
    end
    assign w_fire_evt = fire & ~r_fire_d;
`endif

    assign w_step     = en & tick;
    assign w_top_zero = (top_of(col_top, player_pos) == 4'd0);
    assign w_accept   = ~rst & en & w_fire_evt & (r_cooldown == '0) & w_has_free & ~w_top_zero;
    assign color_req  = w_accept;
    assign col_full   = ~rst & en & w_fire_evt & w_top_zero;
    assign w_load     = ~land_valid | land_ready;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no latch is inferred.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        w_pick_ok  = 1'b0;
        w_pick_idx = '0;
        w_alloc    = '0;
        w_free     = '0;
        // Descending scan leaves the lowest matching index; the slot already in
        // the output register is masked so it is not presented twice.
        for (int k = MAX_SHOTS - 1; k >= 0; k--) begin
            if (w_state[k] == IDLE) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(k);
            end
            if (w_state[k] == LAND && !(land_valid && r_land_idx == IDX_W'(k))) begin
                w_pick_ok  = 1'b1;
                w_pick_idx = IDX_W'(k);
            end
        end
        if (w_accept)                w_alloc[w_free_idx] = 1'b1;
        if (land_valid & land_ready) w_free[r_land_idx]  = 1'b1;
    end

    for (genvar k = 0; k < MAX_SHOTS; k++) begin : g_slot
        shot_slot #(
            .NUM_ROWS   (NUM_ROWS),
            .COLOR_BITS (COLOR_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_alloc   (w_alloc[k]),
            .i_step    (w_step),
            .i_free    (w_free[k]),
            .i_col     (player_pos),
            .i_color   (color_in),
            .i_col_top (col_top),
            .o_state   (w_state[k]),
            .o_row     (w_row[k]),
            .o_col     (w_col[k]),
            .o_color   (w_color[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cooldown <= '0;
            r_land_idx <= '0;
            land_valid <= 1'b0;
            land_col   <= '0;
            land_row   <= '0;
            land_color <= COLOR_W'(DARK);
            shot_vis   <= '0;
        end else begin
            if (w_accept)
                r_cooldown <= CD_W'(COOLDOWN);
            else if (w_step && r_cooldown != '0)
                r_cooldown <= r_cooldown - CD_W'(1);

            if (w_load) begin
                land_valid <= w_pick_ok;
                if (w_pick_ok) begin
                    r_land_idx <= w_pick_idx;
                    land_col   <= w_col[w_pick_idx];
                    land_row   <= w_row[w_pick_idx];
                    land_color <= w_color[w_pick_idx];
                end
            end

            for (int k = 0; k < MAX_SHOTS; k++)
                shot_vis[k*VIS_W +: VIS_W] <= (w_state[k] != IDLE)
                    ? {1'b1, w_row[k], w_col[k], w_color[k]} : '0;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < MAX_SHOTS; k++)
            busy = busy | shot_vis[k*VIS_W + VIS_VALID];
    end

endmodule
